// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and default latencies for the
// multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

endpackage

// File: rtl/mdu_divcore.sv
// mdu_divcore: combinational 32-bit divider, signed or unsigned.
// Signed mode divides magnitudes and restores signs, so the quotient truncates
// toward zero and the remainder follows the dividend. The one overflow case,
// 0x80000000 / -1, falls out naturally as quotient 0x80000000, remainder 0.
// A zero divisor raises div0 and forces both results to 0 to keep X out.
module mdu_divcore (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem,
    output logic        div0
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Magnitude divide followed by sign restoration
    always_comb begin
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (32'd0 - a) : a;
        b_mag = b_neg ? (32'd0 - b) : b;
        div0  = (b == 32'd0);
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (!div0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem = a_neg ? (32'd0 - r_mag) : r_mag;
    end

endmodule

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning HI/LO.
// The result is computed when the op is accepted and parked in pending
// registers; a down-counter holds busy for the configured latency and the
// pending value commits on the edge busy falls.
// Optional macro MDU_CANCEL_EN adds a cancel input that flushes an in-flight op.
module mdu
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_wr;

    logic               kill;
    logic               is_mul;
    logic               is_div;
    logic               go;
    logic               last;
    logic [63:0]        prod;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic               div0;

`ifdef MDU_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign is_mul = (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
    assign is_div = (mdu_op == MDU_DIV)  || (mdu_op == MDU_DIVU);
    assign go     = start && (state == IDLE) && !kill;
    assign last   = (cnt == CNT_W'(1));
    assign busy   = (state != IDLE);

    // Signed or unsigned 64-bit product of the live operands
    always_comb begin
        if (mdu_op == MDU_MULT)
            prod = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
        else
            prod = {32'd0, A} * {32'd0, B};
    end

    mdu_divcore u_divcore (
        .a         (A),
        .b         (B),
        .is_signed (mdu_op == MDU_DIV),
        .quo       (quo),
        .rem       (rem),
        .div0      (div0)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: accept a mul/div in IDLE, return when the count expires or on cancel
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go && is_mul)      state_nxt = MUL;
                else if (go && is_div) state_nxt = DIV;
            end
            MUL, DIV: begin
                if (kill || last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counter, pending result capture, HI/LO writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (state == IDLE) begin
            if (go) begin
                if (is_mul) begin
                    {res_hi, res_lo} <= prod;
                    res_wr           <= 1'b1;
                    cnt              <= CNT_W'(MUL_LAT);
                end else if (is_div) begin
                    res_hi <= rem;
                    res_lo <= quo;
                    res_wr <= !div0;
                    cnt    <= CNT_W'(DIV_LAT);
                end else if (mdu_op == MDU_MTHI) begin
                    hi <= A;
                end else if (mdu_op == MDU_MTLO) begin
                    lo <= A;
                end
            end
        end else begin
            if (kill) begin
                cnt    <= '0;
                res_wr <= 1'b0;
            end else if (last) begin
                cnt    <= '0;
                res_wr <= 1'b0;
                if (res_wr) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with hand-computed results.
module tb_mdu;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        cancel;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    int cnt;

    mdu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
`ifdef MDU_CANCEL_EN
        .cancel (cancel),
`endif
        .mdu_op (mdu_op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        A      = a;
        B      = b;
        @(negedge clk);
        start  = 1'b0;
        A      = 32'hDEAD_BEEF;
        B      = 32'hCAFE_F00D;
    endtask

    // Counts negedges with busy high, bounded at 50.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mdu_op = 3'd0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 00000000", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 00000000", lo); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mult();
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        count_busy(cnt);
        checks++; if (cnt != 5) begin errors++; $display("FAIL mult_lat got %0d want 5", cnt); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        issue(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
        count_busy(cnt);
        checks++; if (cnt != 5) begin errors++; $display("FAIL multu_lat got %0d want 5", cnt); end
        checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi got %h want 00000002", hi); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo got %h want fffffffa", lo); end
    endtask

    task automatic test_div();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(cnt);
        checks++; if (cnt != 10) begin errors++; $display("FAIL div_lat got %0d want 10", cnt); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", hi); end
        issue(OP_DIVU, 32'd7, 32'd2);
        count_busy(cnt);
        checks++; if (cnt != 10) begin errors++; $display("FAIL divu_lat got %0d want 10", cnt); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 00000003", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 00000001", hi); end
    endtask

    task automatic test_mtx_div0();
        issue(OP_MTHI, 32'h1234_5678, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %0b want 0", busy); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h want 12345678", hi); end
        issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %0b want 0", busy); end
        checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL mtlo_lo got %h want 9abcdef0", lo); end
        issue(OP_DIV, 32'd100, 32'd0);
        count_busy(cnt);
        checks++; if (cnt != 10) begin errors++; $display("FAIL div0_lat got %0d want 10", cnt); end
        checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi got %h want 12345678", hi); end
        checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL div0_lo got %h want 9abcdef0", lo); end
        // invalid op code must not disturb anything
        issue(3'd6, 32'h1111_1111, 32'd1);
        checks++; if (busy !== 1'b0 || lo !== 32'h9ABC_DEF0) begin
            errors++; $display("FAIL badop got busy=%0b lo=%h want busy=0 lo=9abcdef0", busy, lo);
        end
    endtask

    task automatic test_busy_ignore();
        issue(OP_MULT, 32'd4, 32'd5);
        for (int k = 1; k <= 5; k++) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy%0d got %0b want 1", k, busy); end
            if (k == 4) begin
                checks++; if (lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL ign_mtlo got %h want 9abcdef0", lo); end
            end
            start = 1'b0;
            if (k == 2) begin start = 1'b1; mdu_op = OP_DIVU; A = 32'd100; B = 32'd7; end
            if (k == 3) begin start = 1'b1; mdu_op = OP_MTLO; A = 32'h0000_DEAD; end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done got %0b want 0", busy); end
        checks++; if (lo !== 32'd20) begin errors++; $display("FAIL ign_lo got %h want 00000014", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ign_hi got %h want 00000000", hi); end
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b0 || lo !== 32'd20) begin
            errors++; $display("FAIL ign_late got busy=%0b lo=%h want busy=0 lo=00000014", busy, lo);
        end
    endtask

    task automatic test_overflow_reset();
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(cnt);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want 00000000", hi); end
        issue(OP_MULT, 32'd7, 32'd9);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rst_mid got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++; $display("FAIL rst_nocommit got busy=%0b hi=%h lo=%h want 0/0/0", busy, hi, lo);
        end
    endtask

`ifdef MDU_CANCEL_EN
    task automatic test_cancel();
        issue(OP_MTHI, 32'h66, 32'd0);
        issue(OP_MTLO, 32'h55, 32'd0);
        issue(OP_MULT, 32'd4, 32'd5);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %0b want 0", busy); end
        repeat (8) @(negedge clk);
        checks++; if (hi !== 32'h66 || lo !== 32'h55) begin
            errors++; $display("FAIL cancel_hilo got %h/%h want 00000066/00000055", hi, lo);
        end
        start = 1'b1; cancel = 1'b1; mdu_op = OP_MULT; A = 32'd4; B = 32'd5;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_start got %0b want 0", busy); end
        issue(OP_MULT, 32'd4, 32'd5);
        count_busy(cnt);
        checks++; if (cnt != 5 || lo !== 32'd20 || hi !== 32'd0) begin
            errors++; $display("FAIL cancel_next got lat=%0d hi=%h lo=%h want 5/00000000/00000014", cnt, hi, lo);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mtx_div0();
        test_busy_ignore();
        test_overflow_reset();
`ifdef MDU_CANCEL_EN
        test_cancel();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
